// File: rtl/ofs_plat_avalon_mem_rdwr_sink_ram.sv
// ofs_plat_avalon_mem_rdwr_sink_ram: Avalon rdwr responder serving burst reads and writes from a local RAM.
module ofs_plat_avalon_mem_rdwr_sink_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 512,
   parameter int BURST_CNT_WIDTH = 3,
   parameter int USER_WIDTH = 4,
   parameter int RD_REQ_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   input  logic rd_read,
   input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
   input  logic [DATA_WIDTH/8-1:0] rd_byteenable,
   input  logic [USER_WIDTH-1:0] rd_user,
   output logic rd_waitrequest,
   output logic [DATA_WIDTH-1:0] rd_readdata,
   output logic rd_readdatavalid,
   output logic [USER_WIDTH-1:0] rd_readresponseuser,
   input  logic [ADDR_WIDTH-1:0] wr_address,
   input  logic wr_write,
   input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
   input  logic [DATA_WIDTH-1:0] wr_writedata,
   input  logic [DATA_WIDTH/8-1:0] wr_byteenable,
   input  logic [USER_WIDTH-1:0] wr_user,
   output logic wr_waitrequest,
   output logic wr_writeresponsevalid,
   output logic [USER_WIDTH-1:0] wr_writeresponseuser
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int PW = $clog2(RD_REQ_DEPTH);
   localparam int QW = ADDR_WIDTH + BURST_CNT_WIDTH + USER_WIDTH;
   typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
   typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [QW-1:0] q [RD_REQ_DEPTH];
   logic [PW:0] wp, rp, q_used, q_used_n;
   logic push, pop, rd_issue, wr_acc, wr_done, unused_rd_be;
   logic [ADDR_WIDTH-1:0] h_addr, rd_addr, rd_addr_n, rd_cur, wr_addr, wr_cur;
   logic [BURST_CNT_WIDTH-1:0] h_cnt, rd_cnt_in, rd_left, rd_left_n, wr_cnt_in, wr_left, wr_left_n;
   logic [USER_WIDTH-1:0] h_user, wr_u;
   rd_state_t rd_st, rd_st_n;
   wr_state_t wr_st, wr_st_n;

   assign unused_rd_be = ^rd_byteenable;
   // A zero burstcount is normalised to a single beat on both channels.
   assign rd_cnt_in = rd_burstcount == '0 ? BURST_CNT_WIDTH'(1) : rd_burstcount;
   assign wr_cnt_in = wr_burstcount == '0 ? BURST_CNT_WIDTH'(1) : wr_burstcount;
   assign push = rd_read && !rd_waitrequest && !reset;
   assign {h_addr, h_cnt, h_user} = q[rp[PW-1:0]];
   assign q_used = wp - rp;
   // Popping in idle also issues beat 0, so the next burst follows the last beat with no bubble.
   assign pop = rd_st == RD_IDLE && q_used != '0 && !reset;
   assign q_used_n = q_used + (PW+1)'(push) - (PW+1)'(pop);
   assign wr_acc = wr_write && !wr_waitrequest && !reset;

   always_comb begin
      rd_issue = pop || rd_st == RD_BURST;
      rd_cur = rd_st == RD_IDLE ? h_addr : rd_addr;
      rd_left_n = (rd_st == RD_IDLE ? h_cnt : rd_left) - BURST_CNT_WIDTH'(1);
      rd_addr_n = rd_cur + ADDR_WIDTH'(1);
      rd_st_n = (rd_issue && rd_left_n != '0) ? RD_BURST : RD_IDLE;
      wr_cur = wr_st == WR_IDLE ? wr_address : wr_addr;
      wr_left_n = (wr_st == WR_IDLE ? wr_cnt_in : wr_left) - BURST_CNT_WIDTH'(1);
      wr_done = wr_acc && wr_left_n == '0;
      wr_st_n = wr_acc ? (wr_left_n == '0 ? WR_IDLE : WR_BURST) : wr_st;
   end

   always_ff @(posedge clk) begin
      if (push) q[wp[PW-1:0]] <= {rd_address, rd_cnt_in, rd_user};
      if (push) assert (rd_burstcount != '0);
      if (wr_acc && wr_st == WR_IDLE) assert (wr_burstcount != '0);
      rd_addr <= rd_addr_n;
      rd_left <= rd_left_n;
      rd_readdata <= reset ? '0 : mem[rd_cur];
      if (wr_acc) begin
         wr_addr <= wr_cur + ADDR_WIDTH'(1);
         wr_left <= wr_left_n;
      end
      if (wr_acc && wr_st == WR_IDLE) wr_u <= wr_user;
      wr_waitrequest <= reset;
      if (reset) begin
         wp <= '0;
         rp <= '0;
         rd_st <= RD_IDLE;
         wr_st <= WR_IDLE;
         rd_waitrequest <= 1'b1;
         rd_readdatavalid <= 1'b0;
         rd_readresponseuser <= '0;
         wr_writeresponsevalid <= 1'b0;
         wr_writeresponseuser <= '0;
      end else begin
         wp <= wp + (PW+1)'(push);
         rp <= rp + (PW+1)'(pop);
         rd_st <= rd_st_n;
         wr_st <= wr_st_n;
         rd_waitrequest <= q_used_n == (PW+1)'(RD_REQ_DEPTH);
         rd_readdatavalid <= rd_issue;
         rd_readresponseuser <= pop ? h_user : '0;
         wr_writeresponsevalid <= wr_done;
         wr_writeresponseuser <= wr_done ? (wr_st == WR_IDLE ? wr_user : wr_u) : '0;
      end
   end

   // Separate write port: reads above sample pre-write contents on a same-cycle collision.
   always_ff @(posedge clk)
      for (int i = 0; i < BE_WIDTH; i++)
         if (wr_acc && wr_byteenable[i]) mem[wr_cur][i*8 +: 8] <= wr_writedata[i*8 +: 8];
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_sink_ram.sv
// tb_ofs_plat_avalon_mem_rdwr_sink_ram: scoreboard bench for the rdwr sink RAM.
module tb_ofs_plat_avalon_mem_rdwr_sink_ram;
   localparam int AW = 10, DW = 512, BW = 3, UW = 4, BEW = DW / 8;
   typedef struct packed {logic [DW-1:0] d; logic [UW-1:0] u;} rd_exp_t;

   logic clk = 0, reset = 1;
   logic [AW-1:0] rd_address = '0, wr_address = '0;
   logic rd_read = 0, wr_write = 0;
   logic [BW-1:0] rd_burstcount = '0, wr_burstcount = '0;
   logic [BEW-1:0] rd_byteenable = '1, wr_byteenable = '0;
   logic [UW-1:0] rd_user = '0, wr_user = '0;
   logic [DW-1:0] wr_writedata = '0;
   logic rd_waitrequest, rd_readdatavalid, wr_waitrequest, wr_writeresponsevalid;
   logic [DW-1:0] rd_readdata;
   logic [UW-1:0] rd_readresponseuser, wr_writeresponseuser;

   rd_exp_t exp_rd[$];
   logic [UW-1:0] exp_wr[$];
   logic [DW-1:0] shadow [2**AW];
   rd_exp_t mon_e;
   logic [UW-1:0] mon_u;
   int passed = 0, total = 0, cyc = 0, last_cyc = 0, gaps = 0;
   bit contig = 0, seen = 0, stalled = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ofs_plat_avalon_mem_rdwr_sink_ram dut (
      .clk(clk), .reset(reset),
      .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
      .rd_byteenable(rd_byteenable), .rd_user(rd_user), .rd_waitrequest(rd_waitrequest),
      .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
      .rd_readresponseuser(rd_readresponseuser),
      .wr_address(wr_address), .wr_write(wr_write), .wr_burstcount(wr_burstcount),
      .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable), .wr_user(wr_user),
      .wr_waitrequest(wr_waitrequest), .wr_writeresponsevalid(wr_writeresponsevalid),
      .wr_writeresponseuser(wr_writeresponseuser)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] mk(input int k);
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = 32'(k) * 32'h9E3779B1 + 32'(i);
      return v;
   endfunction

   task automatic sh_wr(input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
      for (int j = 0; j < BEW; j++) if (be[j]) shadow[a % (2**AW)][j*8 +: 8] = d[j*8 +: 8];
   endtask

   task automatic rd_req(input int a, input int n, input int u);
      int b = 0;
      rd_address = AW'(a); rd_burstcount = BW'(n); rd_user = UW'(u); rd_read = 1;
      @(negedge clk);
      while (rd_waitrequest) begin
         stalled = 1;
         if (++b > 100) begin
            $display("FAIL rd_accept: waitrequest stuck high");
            $fatal(1);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      rd_read = 0;
      for (int i = 0; i < n; i++)
         exp_rd.push_back({shadow[(a + i) % (2**AW)], i == 0 ? UW'(u) : UW'(0)});
   endtask

   task automatic wr_beat(input int a, input int n, input int u, input logic [DW-1:0] d, input logic [BEW-1:0] be);
      wr_address = AW'(a); wr_burstcount = BW'(n); wr_user = UW'(u);
      wr_writedata = d; wr_byteenable = be; wr_write = 1;
      @(negedge clk);
      chk("wr_waitrequest_idle", wr_waitrequest, 0);
      @(posedge clk); #1;
      wr_write = 0;
   endtask

   task automatic wr_burst(input int a, input int n, input int u, input int k);
      for (int i = 0; i < n; i++) begin
         sh_wr(a + i, mk(k + i), '1);
         wr_beat(a, n, u, mk(k + i), '1);
      end
      exp_wr.push_back(UW'(u));
   endtask

   task automatic drain();
      int b = 0;
      while ((exp_rd.size() != 0 || exp_wr.size() != 0) && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      chk("drain_outstanding", exp_rd.size() + exp_wr.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) if (!reset) begin
      if (rd_readdatavalid) begin
         if (contig) begin
            if (seen && cyc != last_cyc + 1) gaps++;
            seen = 1;
            last_cyc = cyc;
         end
         if (exp_rd.size() == 0) begin
            total++;
            $display("FAIL rd_unexpected_beat: got beat %h, expected none", rd_readdata);
         end else begin
            mon_e = exp_rd.pop_front();
            chk("rd_data", rd_readdata, mon_e.d);
            chk("rd_user", rd_readresponseuser, mon_e.u);
         end
      end
      if (wr_writeresponsevalid) begin
         if (exp_wr.size() == 0) begin
            total++;
            $display("FAIL wr_unexpected_resp: got user %h, expected none", wr_writeresponseuser);
         end else begin
            mon_u = exp_wr.pop_front();
            chk("wr_resp_user", wr_writeresponseuser, mon_u);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rd_wait", rd_waitrequest, 1);
      chk("reset_wr_wait", wr_waitrequest, 1);
      chk("reset_rd_valid", rd_readdatavalid, 0);
      chk("reset_wr_resp", wr_writeresponsevalid, 0);
      chk("reset_rd_data", rd_readdata, 0);
      chk("reset_rd_user", rd_readresponseuser, 0);
      reset = 0;
      @(posedge clk); #1;
      chk("post_reset_rd_wait", rd_waitrequest, 0);
      chk("post_reset_wr_wait", wr_waitrequest, 0);

      // Prefill 0x100..0x11F and 0x200..0x203 with back-to-back write bursts.
      for (int b = 0; b < 8; b++) wr_burst(32'h100 + 4*b, 4, b, 100 + 4*b);
      wr_burst(32'h200, 4, 9, 200);
      drain();

      // Write burst 4 at 0x010 then read it back with latency checks.
      wr_burst(32'h010, 4, 5, 10);
      chk("wr_resp_after_last", wr_writeresponsevalid, 1);
      @(posedge clk); #1;
      chk("wr_resp_one_cycle", wr_writeresponsevalid, 0);
      drain();
      rd_req(32'h010, 4, 3);
      chk("rd_lat_t1", rd_readdatavalid, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rd_lat_beat", rd_readdatavalid, 1);
      end
      @(posedge clk); #1;
      chk("rd_after_last", rd_readdatavalid, 0);
      drain();

      // Byte-enable merge into an all-ones line.
      sh_wr(32'h020, '1, '1);
      wr_beat(32'h020, 1, 1, '1, '1);
      exp_wr.push_back(UW'(1));
      sh_wr(32'h020, DW'(8'hAA), BEW'(1));
      wr_beat(32'h020, 1, 2, DW'(8'hAA), BEW'(1));
      exp_wr.push_back(UW'(2));
      drain();
      rd_req(32'h020, 1, 3);
      void'(exp_rd.pop_back());
      exp_rd.push_back({{{(BEW-1){8'hFF}}, 8'hAA}, UW'(3)});
      drain();

      // Six queued bursts: queue fills, beats stay contiguous and ordered.
      contig = 1; seen = 0; gaps = 0; stalled = 0;
      for (int i = 0; i < 6; i++) rd_req(32'h100 + 4*i, 4, i);
      drain();
      contig = 0;
      chk("queue_full_stall", stalled, 1);
      chk("rd_contiguous_gaps", gaps, 0);

      // Address wrap at the top of the RAM.
      wr_burst(32'h3FE, 4, 6, 40);
      drain();
      rd_req(32'h3FE, 4, 9);
      drain();

      // Same-cycle read and write to 0x030: old then new data.
      sh_wr(32'h030, mk(50), '1);
      wr_beat(32'h030, 1, 4, mk(50), '1);
      exp_wr.push_back(UW'(4));
      drain();
      rd_address = AW'(32'h030); rd_burstcount = BW'(1); rd_user = UW'(1); rd_read = 1;
      @(negedge clk);
      chk("rbw_rd_wait_a", rd_waitrequest, 0);
      @(posedge clk); #1;
      rd_user = UW'(2);
      wr_address = AW'(32'h030); wr_burstcount = BW'(1); wr_user = UW'(7);
      wr_writedata = mk(51); wr_byteenable = '1; wr_write = 1;
      exp_rd.push_back({mk(50), UW'(1)});
      exp_rd.push_back({mk(51), UW'(2)});
      exp_wr.push_back(UW'(7));
      @(negedge clk);
      chk("rbw_rd_wait_b", rd_waitrequest, 0);
      @(posedge clk); #1;
      rd_read = 0; wr_write = 0;
      sh_wr(32'h030, mk(51), '1);
      drain();

      // Reset during read beat 1 and mid write burst.
      sh_wr(32'h200, mk(60), '1);
      wr_beat(32'h200, 4, 8, mk(60), '1);
      sh_wr(32'h201, mk(61), '1);
      wr_beat(32'h201, 4, 8, mk(61), '1);
      rd_req(32'h100, 4, 10);
      repeat (3) void'(exp_rd.pop_back());
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_beat1_valid", rd_readdatavalid, 1);
      reset = 1;
      @(posedge clk); #1;
      chk("rst_rd_valid", rd_readdatavalid, 0);
      chk("rst_rd_wait", rd_waitrequest, 1);
      chk("rst_wr_wait", wr_waitrequest, 1);
      chk("rst_wr_resp", wr_writeresponsevalid, 0);
      @(posedge clk); #1;
      reset = 0;
      chk("rst_rel_rd_wait", rd_waitrequest, 1);
      chk("rst_rel_wr_wait", wr_waitrequest, 1);
      @(posedge clk); #1;
      chk("rst_done_rd_wait", rd_waitrequest, 0);
      chk("rst_done_wr_wait", wr_waitrequest, 0);
      wr_burst(32'h300, 2, 11, 70);
      drain();
      rd_req(32'h200, 4, 12);
      rd_req(32'h300, 2, 13);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
